// File: rtl/sim_mem_responder_pkg.sv
// Shared types and constants for the simulation memory responder and its stall generator.
package sim_mem_responder_pkg;

    localparam int unsigned ADDR_W      = 32;
    localparam int unsigned DATA_W      = 32;
    localparam int unsigned STRB_W      = DATA_W / 8;
    localparam int unsigned LFSR_W      = 23;
    localparam int unsigned LFSR_TAP_HI = 22;
    localparam int unsigned LFSR_TAP_LO = 17;

    typedef enum logic {
        RSP_IDLE  = 1'b0,
        RSP_VALID = 1'b1
    } rsp_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/sim_stall_gen.sv
// LFSR-driven gate generator for the request and response channels, with a
// per-channel stall cap that forces a gate open after MAX_STALL closed cycles.
module sim_stall_gen
    import sim_mem_responder_pkg::*;
#(
    parameter int unsigned       RAND_EN   = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 23'h557ea2,
    parameter int unsigned       MAX_STALL = 7
) (
    input  logic clk,
    input  logic resetn,
    input  logic req_pending,
    input  logic rsp_pending,
    output logic req_open_c,
    output logic rsp_open_c
);

    localparam int unsigned      CNT_W    = $clog2(MAX_STALL + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_STALL);
    localparam logic             RAND_OFF = (RAND_EN == 0);

    logic [LFSR_W-1:0] lfsr_q;
    logic [CNT_W-1:0]  req_cnt_q, req_cnt_d;
    logic [CNT_W-1:0]  rsp_cnt_q, rsp_cnt_d;

    assign req_open_c = ~(lfsr_q[3] & lfsr_q[9])  | RAND_OFF | (req_cnt_q == CNT_MAX);
    assign rsp_open_c = ~(lfsr_q[5] & lfsr_q[14]) | RAND_OFF | (rsp_cnt_q == CNT_MAX);

    // A closed gate implies the counter is below CNT_MAX, so the increment cannot wrap.
    function automatic logic [CNT_W-1:0] stall_next(input logic [CNT_W-1:0] cnt,
                                                    input logic open, input logic pending);
        if (open) begin
            return '0;
        end
        if (pending) begin
            return cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

    always_comb begin
        req_cnt_d = stall_next(req_cnt_q, req_open_c, req_pending);
        rsp_cnt_d = stall_next(rsp_cnt_q, rsp_open_c, rsp_pending);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr_q    <= LFSR_SEED;
            req_cnt_q <= '0;
            rsp_cnt_q <= '0;
        end else begin
            lfsr_q    <= lfsr_next(lfsr_q);
            req_cnt_q <= req_cnt_d;
            rsp_cnt_q <= rsp_cnt_d;
        end
    end

endmodule

// File: rtl/sim_mem_responder.sv
// Simulation memory target for the custom_cpu memory interface: byte-strobed
// writes, in-order read responses through a FIFO, randomly throttled handshakes.
module sim_mem_responder
    import sim_mem_responder_pkg::*;
#(
    parameter int unsigned       MEM_AW    = 12,
    parameter int unsigned       RSP_DEPTH = 4,
    parameter int unsigned       RAND_EN   = 1,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 23'h557ea2,
    parameter int unsigned       MAX_STALL = 7
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] Address,
    input  logic              MemWrite,
    input  logic [DATA_W-1:0] Write_data,
    input  logic [STRB_W-1:0] Write_strb,
    input  logic              MemRead,
    output logic              Mem_Req_Ready,
    output logic [DATA_W-1:0] Read_data,
    output logic              Read_data_Valid,
    input  logic              Read_data_Ready,
    output logic              proto_err
);

    localparam int unsigned MEM_DEPTH = 1 << MEM_AW;
    localparam int unsigned PTR_W     = $clog2(RSP_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    logic [DATA_W-1:0] mem_q  [MEM_DEPTH];
    logic [DATA_W-1:0] fifo_q [RSP_DEPTH];

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, unpres_c;
    rsp_state_e        state_q, state_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              req_rdy_q, req_rdy_d;
    logic              proto_err_q, proto_err_d;

    logic              req_open_c, rsp_open_c;
    logic [MEM_AW-1:0] widx_c;
    logic              req_fire_c, wr_fire_c, rd_fire_c, hs_c, pop_c;
    logic              unused_addr_c;

    assign widx_c        = Address[MEM_AW+1:2];
    assign unused_addr_c = ^{Address[ADDR_W-1:MEM_AW+2], Address[1:0]};

    assign req_fire_c = req_rdy_q & (MemRead ^ MemWrite);
    assign wr_fire_c  = req_fire_c & MemWrite;
    assign rd_fire_c  = req_fire_c & MemRead;
    assign hs_c       = (state_q == RSP_VALID) & Read_data_Ready;

    // count_q holds every entry until its handshake, so the one being presented still occupies a slot.
    assign unpres_c = count_q - CNT_W'(state_q == RSP_VALID);
    assign pop_c    = rsp_open_c & (unpres_c != '0) & ((state_q == RSP_IDLE) | Read_data_Ready);

    sim_stall_gen #(
        .RAND_EN   (RAND_EN),
        .LFSR_SEED (LFSR_SEED),
        .MAX_STALL (MAX_STALL)
    ) u_stall (
        .clk         (clk),
        .resetn      (resetn),
        .req_pending (MemRead | MemWrite),
        .rsp_pending (unpres_c != '0),
        .req_open_c  (req_open_c),
        .rsp_open_c  (rsp_open_c)
    );

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q + CNT_W'(rd_fire_c) - CNT_W'(hs_c);
        proto_err_d = proto_err_q | (req_rdy_q & MemRead & MemWrite);

        if (rd_fire_c) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop_c) begin
            state_d  = RSP_VALID;
            rdata_d  = fifo_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else if (hs_c) begin
            state_d  = RSP_IDLE;
        end

        // Ready for the next cycle looks at next-cycle occupancy so a full FIFO is never overrun.
        req_rdy_d = req_open_c & (count_d != CNT_W'(RSP_DEPTH));
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= RSP_IDLE;
            rdata_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            req_rdy_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            req_rdy_q   <= req_rdy_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Storage is deliberately unreset so memory contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_fire_c) begin
            for (int i = 0; i < int'(STRB_W); i++) begin
                if (Write_strb[i]) begin
                    mem_q[widx_c][8*i +: 8] <= Write_data[8*i +: 8];
                end
            end
        end
        if (rd_fire_c) begin
            fifo_q[wr_ptr_q] <= mem_q[widx_c];
        end
    end

    assign Mem_Req_Ready   = req_rdy_q;
    assign Read_data       = rdata_q;
    assign Read_data_Valid = (state_q == RSP_VALID);
    assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_sim_mem_responder.sv
// Bench for sim_mem_responder: directed table on an unthrottled instance and a
// randomized run against a memory/queue model on a throttled instance.
module tb_sim_mem_responder;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned MAXS   = 7;
    localparam int          NOPS   = 1000;
    localparam int          NPOOL  = 16;

    logic        clk;
    logic        resetn;

    logic [31:0] m0_addr, m0_wdata, m0_rdata;
    logic [3:0]  m0_strb;
    logic        m0_rd, m0_wr, m0_rrdy, m0_ready, m0_valid, m0_perr;

    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [3:0]  m1_strb;
    logic        m1_rd, m1_wr, m1_rrdy, m1_ready, m1_valid, m1_perr;

    int checks   = 0;
    int failures = 0;

    sim_mem_responder #(.MEM_AW(12), .RSP_DEPTH(DEPTH), .RAND_EN(0), .MAX_STALL(MAXS)) dut0 (
        .clk(clk), .resetn(resetn), .Address(m0_addr), .MemWrite(m0_wr),
        .Write_data(m0_wdata), .Write_strb(m0_strb), .MemRead(m0_rd),
        .Mem_Req_Ready(m0_ready), .Read_data(m0_rdata), .Read_data_Valid(m0_valid),
        .Read_data_Ready(m0_rrdy), .proto_err(m0_perr)
    );

    sim_mem_responder #(.MEM_AW(12), .RSP_DEPTH(DEPTH), .RAND_EN(1), .MAX_STALL(MAXS)) dut1 (
        .clk(clk), .resetn(resetn), .Address(m1_addr), .MemWrite(m1_wr),
        .Write_data(m1_wdata), .Write_strb(m1_strb), .MemRead(m1_rd),
        .Mem_Req_Ready(m1_ready), .Read_data(m1_rdata), .Read_data_Valid(m1_valid),
        .Read_data_Ready(m1_rrdy), .proto_err(m1_perr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #10000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic d0_req(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        m0_addr = a; m0_wdata = d; m0_strb = s; m0_rd = r; m0_wr = w;
        while (m0_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("d0_req_timeout", 32'(m0_ready), 32'd1);
        @(posedge clk); #1;
        m0_rd = 1'b0; m0_wr = 1'b0;
    endtask

    task automatic d0_read(input logic [31:0] a, input logic [31:0] e, input string nm);
        d0_req(1'b1, 1'b0, a, 32'h0, 4'h0);
        chk({nm, "_lat_min"}, 32'(m0_valid), 32'd0);
        @(posedge clk); #1;
        chk({nm, "_valid"}, 32'(m0_valid), 32'd1);
        chk({nm, "_data"}, m0_rdata, e);
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
    } vec_t;

    vec_t        tbl [15];
    logic [31:0] t3a [5];
    logic [31:0] t3e [5];
    logic [31:0] got [$];
    logic [31:0] mdl [int];
    logic [31:0] expq [$];
    int          pool [NPOOL];

    initial begin
        m0_addr = '0; m0_wdata = '0; m0_strb = '0; m0_rd = 0; m0_wr = 0; m0_rrdy = 1;
        m1_addr = '0; m1_wdata = '0; m1_strb = '0; m1_rd = 0; m1_wr = 0; m1_rrdy = 1;

        tbl[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF};
        tbl[1]  = '{1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'h0};
        tbl[2]  = '{1'b1, 32'h0000_0020, 32'h1122_3344, 4'hF};
        tbl[3]  = '{1'b1, 32'h0000_0020, 32'hAABB_CCDD, 4'b0101};
        tbl[4]  = '{1'b0, 32'h0000_0020, 32'h11BB_33DD, 4'h0};
        tbl[5]  = '{1'b1, 32'h0000_0020, 32'h0000_0000, 4'h0};
        tbl[6]  = '{1'b0, 32'h0000_0020, 32'h11BB_33DD, 4'h0};
        tbl[7]  = '{1'b1, 32'h0000_4030, 32'h1234_5678, 4'hF};
        tbl[8]  = '{1'b0, 32'h0000_0030, 32'h1234_5678, 4'h0};
        tbl[9]  = '{1'b0, 32'hFFFF_C031, 32'h1234_5678, 4'h0};
        tbl[10] = '{1'b1, 32'h0000_3FFC, 32'hCAFE_F00D, 4'hF};
        tbl[11] = '{1'b1, 32'h0000_3FFC, 32'h9900_0000, 4'h8};
        tbl[12] = '{1'b0, 32'h0000_3FFC, 32'h99FE_F00D, 4'h0};
        tbl[13] = '{1'b1, 32'h0000_0000, 32'h55AA_55AA, 4'hF};
        tbl[14] = '{1'b0, 32'h0000_0000, 32'h55AA_55AA, 4'h0};

        t3a[0] = 32'h10; t3a[1] = 32'h20; t3a[2] = 32'h30; t3a[3] = 32'h3FFC; t3a[4] = 32'h0;
        t3e[0] = 32'hDEAD_BEEF; t3e[1] = 32'h11BB_33DD; t3e[2] = 32'h1234_5678;
        t3e[3] = 32'h99FE_F00D; t3e[4] = 32'h55AA_55AA;

        // Reset state
        resetn = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("rst_ready", 32'(m0_ready), 32'd0);
        chk("rst_valid", 32'(m0_valid), 32'd0);
        chk("rst_rdata", m0_rdata, 32'd0);
        chk("rst_perr", 32'(m0_perr), 32'd0);
        chk("rst_ready1", 32'(m1_ready), 32'd0);
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk); #1;

        // Directed table: writes, strobes, zero strobe, aliasing, top word
        for (int i = 0; i < 15; i++) begin
            if (tbl[i].is_wr) d0_req(1'b0, 1'b1, tbl[i].addr, tbl[i].data, tbl[i].strb);
            else d0_read(tbl[i].addr, tbl[i].data, $sformatf("tbl%0d", i));
        end

        // Backpressure: four reads fill the FIFO, fifth waits for a pop
        m0_rrdy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            m0_addr = t3a[i]; m0_rd = 1'b1;
            chk($sformatf("t3_accept%0d", i), 32'(m0_ready), 32'd1);
            @(posedge clk); #1;
        end
        begin
            logic seen_rdy;
            seen_rdy = 1'b0;
            m0_addr = t3a[4]; m0_rd = 1'b1;
            repeat (6) begin
                seen_rdy = seen_rdy | m0_ready;
                @(posedge clk); #1;
            end
            chk("t3_full_block", 32'(seen_rdy), 32'd0);
            chk("t3_valid_held", 32'(m0_valid), 32'd1);
            got = {};
            got.push_back(m0_rdata);
            m0_rrdy = 1'b1;
            @(posedge clk); #1;
            chk("t3_ready_after_pop", 32'(m0_ready), 32'd1);
            for (int c = 0; c < 20 && got.size() < 5; c++) begin
                if (m0_valid) got.push_back(m0_rdata);
                @(posedge clk); #1;
                if (c == 0) m0_rd = 1'b0;
            end
            m0_rd = 1'b0;
            chk("t3_count", 32'(got.size()), 32'd5);
            for (int i = 0; i < 5 && i < got.size(); i++) chk($sformatf("t3_order%0d", i), got[i], t3e[i]);
        end

        // Protocol error: simultaneous read and write
        begin
            logic seen_v;
            seen_v = 1'b0;
            chk("t5_perr_before", 32'(m0_perr), 32'd0);
            d0_req(1'b1, 1'b1, 32'h0, 32'hFFFF_FFFF, 4'hF);
            chk("t5_perr_set", 32'(m0_perr), 32'd1);
            repeat (4) begin
                seen_v = seen_v | m0_valid;
                @(posedge clk); #1;
            end
            chk("t5_no_rsp", 32'(seen_v), 32'd0);
            chk("t5_perr_sticky", 32'(m0_perr), 32'd1);
            d0_read(32'h0, 32'h55AA_55AA, "t5_mem_unchanged");
        end

        // Randomized run on the throttled instance
        begin
            bit          req_act, acc_next, v_prev, r_prev, fin, cur_wr;
            logic [31:0] d_prev, cur_data, a, e, nv;
            logic [3:0]  cur_strb;
            logic [11:0] cur_idx;
            int          occ, done_ops, issued, idle, req_run, rsp_run, max_req, max_rsp, wait_cyc;
            req_act = 0; acc_next = 0; v_prev = 0; r_prev = 0; fin = 0; cur_wr = 0;
            d_prev = '0; cur_data = '0; cur_strb = '0; cur_idx = '0;
            occ = 0; done_ops = 0; issued = 0; idle = 0;
            req_run = 0; rsp_run = 0; max_req = 0; max_rsp = 0; wait_cyc = 0;
            for (int k = 0; k < NPOOL; k++) pool[k] = int'($urandom_range(0, 4095));
            for (int cyc = 0; cyc < 30000 && !fin; cyc++) begin
                @(posedge clk); #1;
                if (acc_next) begin
                    if (cur_wr) begin
                        nv = mdl.exists(int'(cur_idx)) ? mdl[int'(cur_idx)] : 32'h0;
                        for (int b = 0; b < 4; b++) if (cur_strb[b]) nv[8*b +: 8] = cur_data[8*b +: 8];
                        mdl[int'(cur_idx)] = nv;
                    end else begin
                        expq.push_back(mdl[int'(cur_idx)]);
                        occ++;
                    end
                    req_act = 0; m1_rd = 0; m1_wr = 0; done_ops++;
                end
                if (v_prev && r_prev) occ--;
                if (v_prev && !r_prev) begin
                    chk("t4_valid_hold", 32'(m1_valid), 32'd1);
                    chk("t4_data_hold", m1_rdata, d_prev);
                end
                m1_rrdy = ($urandom_range(0, 3) != 0);
                if (m1_valid && m1_rrdy) begin
                    if (expq.size() == 0) chk("t4_extra_rsp", 32'(m1_valid), 32'd0);
                    else begin
                        e = expq.pop_front();
                        chk("t4_rdata", m1_rdata, e);
                    end
                end
                if (!req_act && issued < NOPS) begin
                    if (idle > 0) idle--;
                    else begin
                        cur_idx  = 12'(pool[$urandom_range(0, NPOOL-1)]);
                        cur_wr   = (issued < NPOOL) ? 1'b1 : ($urandom_range(0, 1) == 1);
                        if (issued < NPOOL) cur_idx = 12'(pool[issued]);
                        cur_data = $urandom();
                        cur_strb = (issued < NPOOL) ? 4'hF : 4'($urandom_range(0, 15));
                        a = $urandom();
                        a[13:2] = cur_idx;
                        m1_addr = a; m1_wdata = cur_data; m1_strb = cur_strb;
                        m1_wr = cur_wr; m1_rd = !cur_wr;
                        req_act = 1; wait_cyc = 0; issued++;
                        idle = int'($urandom_range(0, 2));
                    end
                end
                if (req_act) wait_cyc++;
                if (wait_cyc > 500) begin
                    chk("t4_req_timeout", 32'(req_act), 32'd0);
                    fin = 1;
                end
                if (req_act && occ < int'(DEPTH) && !m1_ready) req_run++; else req_run = 0;
                if (occ > 0 && !m1_valid) rsp_run++; else rsp_run = 0;
                if (req_run > max_req) max_req = req_run;
                if (rsp_run > max_rsp) max_rsp = rsp_run;
                acc_next = req_act && m1_ready;
                v_prev = m1_valid; r_prev = m1_rrdy; d_prev = m1_rdata;
                if (done_ops == NOPS && occ == 0 && !req_act) fin = 1;
            end
            chk("t4_all_ops", 32'(done_ops), 32'(NOPS));
            chk("t4_queue_drained", 32'(expq.size()), 32'd0);
            chk("t4_req_stall_cap", 32'(max_req > int'(MAXS) + 2), 32'd0);
            chk("t4_rsp_stall_cap", 32'(max_rsp > int'(MAXS) + 2), 32'd0);
            chk("t4_perr_clear", 32'(m1_perr), 32'd0);
            m1_rd = 0; m1_wr = 0;
        end

        // Async reset with responses queued; memory survives
        m0_rrdy = 1'b0;
        d0_req(1'b1, 1'b0, 32'h10, 32'h0, 4'h0);
        d0_req(1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
        d0_req(1'b1, 1'b0, 32'h30, 32'h0, 4'h0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t6_valid_before", 32'(m0_valid), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("t6_valid_async", 32'(m0_valid), 32'd0);
        chk("t6_ready_async", 32'(m0_ready), 32'd0);
        chk("t6_rdata_async", m0_rdata, 32'd0);
        chk("t6_perr_async", 32'(m0_perr), 32'd0);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        m0_rrdy = 1'b1;
        begin
            logic seen_v;
            seen_v = 1'b0;
            repeat (5) begin
                @(posedge clk); #1;
                seen_v = seen_v | m0_valid;
            end
            chk("t6_fifo_empty", 32'(seen_v), 32'd0);
        end
        d0_read(32'h10, 32'hDEAD_BEEF, "t6_retain_a");
        d0_read(32'h30, 32'h1234_5678, "t6_retain_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
